// File: rtl/disp_pkg.sv
// Shared geometry defaults, field widths and handshake state encoding for the display scheduler.
// Pure declarations: no latency, no flow control.
package disp_pkg;
  localparam int HACT_DEF = 800;
  localparam int VACT_DEF = 600;
  localparam int XY_W     = 11;
  localparam int MODE_W   = 3;
  localparam int SPEED_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } hs_state_t;

  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [SPEED_W-1:0] speed;
  } cfg_t;
endpackage

// File: rtl/frame_div.sv
// Frame divider: anim_tick pulses one cycle after every (speed+1)-th frame start.
// Latency 1 cycle from fs; no backpressure, a commit restarts the count.
module frame_div
  import disp_pkg::*;
(
  input  logic               clk,
  input  logic               RSTn,
  input  logic               fs,
  input  logic               commit,
  input  logic [SPEED_W-1:0] speed,
  output logic               anim_tick
);

  logic [SPEED_W-1:0] div;

  // speed is the value in force before any same-cycle commit lands
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      div       <= '0;
      anim_tick <= 1'b0;
    end else begin
      anim_tick <= fs && (div == speed);
      if (commit)
        div <= '0;
      else if (fs)
        div <= (div == speed) ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: active-area x/y, frame count, animation tick and frame-aligned mode commit.
// Outputs registered 1 cycle after timing inputs; cfg_req is a level held until the cfg_ack pulse.
module disp_sched
  import disp_pkg::*;
#(
  parameter int HACT = HACT_DEF,
  parameter int VACT = VACT_DEF
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic               hvalid,
  input  logic               vvalid,
  input  logic               vsync,
  input  logic               cfg_req,
  input  logic [MODE_W-1:0]  cfg_mode,
  input  logic [SPEED_W-1:0] cfg_speed,
  output logic               cfg_ack,
  output logic [MODE_W-1:0]  mode,
  output logic [XY_W-1:0]    x,
  output logic [XY_W-1:0]    y,
  output logic               pix_en,
  output logic [7:0]         frame_cnt,
  output logic               anim_tick,
  output logic               sync_err
);

  localparam logic [XY_W-1:0] X_MAX = XY_W'(HACT - 1);
  localparam logic [XY_W-1:0] Y_MAX = XY_W'(VACT - 1);

  logic               vsync_q;
  logic               fs;
  logic               line_end;
  logic               y_full;
  logic               x_ovf;
  logic               y_ovf;
  logic               commit;
  hs_state_t          state;
  cfg_t               shadow;
  logic [SPEED_W-1:0] speed;

  assign fs       = vsync & ~vsync_q;
  assign line_end = pix_en & ~hvalid;
  assign x_ovf    = hvalid & pix_en & (x == X_MAX);
  // y stays at the last row; a further line starting in the same frame is the overflow
  assign y_ovf    = hvalid & ~pix_en & vvalid & y_full;
  assign commit   = (state == ST_PEND) & fs;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      vsync_q   <= 1'b0;
      pix_en    <= 1'b0;
      x         <= '0;
      y         <= '0;
      y_full    <= 1'b0;
      frame_cnt <= '0;
      sync_err  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      pix_en  <= hvalid;

      if (!hvalid || !pix_en)
        x <= '0;
      else if (x != X_MAX)
        x <= x + 1'b1;

      if (!vvalid) begin
        y      <= '0;
        y_full <= 1'b0;
      end else if (line_end) begin
        if (y == Y_MAX)
          y_full <= 1'b1;
        else
          y <= y + 1'b1;
      end

      if (x_ovf || y_ovf)
        sync_err <= 1'b1;

      if (fs)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      mode    <= '0;
      speed   <= '0;
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          // a request landing on fs only latches; it commits on the following fs
          if (cfg_req) begin
            shadow <= '{mode: cfg_mode, speed: cfg_speed};
            state  <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (fs) begin
            mode    <= shadow.mode;
            speed   <= shadow.speed;
            cfg_ack <= 1'b1;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!cfg_req)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  frame_div u_frame_div (
    .clk       (clk),
    .RSTn      (RSTn),
    .fs        (fs),
    .commit    (commit),
    .speed     (speed),
    .anim_tick (anim_tick)
  );

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched on a reduced raster; pixel coordinates are scoreboarded.
module tb_disp_sched;
  localparam int HACT = 16;
  localparam int VACT = 8;
  localparam int HTOT = 24;
  localparam int VTOT = 12;

  logic        clk = 1'b0;
  logic        RSTn = 1'b1;
  logic        hvalid = 1'b0;
  logic        vvalid = 1'b0;
  logic        vsync = 1'b0;
  logic        cfg_req = 1'b0;
  logic [2:0]  cfg_mode = 3'd0;
  logic [3:0]  cfg_speed = 4'd0;
  logic        cfg_ack;
  logic [2:0]  mode;
  logic [10:0] x;
  logic [10:0] y;
  logic        pix_en;
  logic [7:0]  frame_cnt;
  logic        anim_tick;
  logic        sync_err;

  int          checks = 0;
  int          errors = 0;
  int          pix_cnt = 0;
  int          ack_cnt = 0;
  int          tick_cnt = 0;
  int          exp_ticks = 0;
  logic [31:0] xy_q[$];
  logic [31:0] e_xy;
  logic [2:0]  exp_mode = 3'd0;
  logic [7:0]  exp_fc = 8'd0;

  always #5 clk = ~clk;

  disp_sched #(.HACT(HACT), .VACT(VACT)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .hvalid    (hvalid),
    .vvalid    (vvalid),
    .vsync     (vsync),
    .cfg_req   (cfg_req),
    .cfg_mode  (cfg_mode),
    .cfg_speed (cfg_speed),
    .cfg_ack   (cfg_ack),
    .mode      (mode),
    .x         (x),
    .y         (y),
    .pix_en    (pix_en),
    .frame_cnt (frame_cnt),
    .anim_tick (anim_tick),
    .sync_err  (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_mode", mode, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_pix_en", pix_en, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_anim_tick", anim_tick, 0);
    chk("rst_cfg_ack", cfg_ack, 0);
    chk("rst_sync_err", sync_err, 0);
  endtask

  // Scoreboard side: every visible pixel must match the next expected coordinate.
  always @(negedge clk) begin
    if (RSTn) begin
      if (cfg_ack === 1'b1) ack_cnt++;
      if (anim_tick === 1'b1) tick_cnt++;
      if (pix_en === 1'b1) begin
        pix_cnt++;
        if (xy_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL pix_unexpected observed x=%0d y=%0d expected no pixel", x, y);
        end else begin
          e_xy = xy_q.pop_front();
          chk("pix_xy", {10'd0, x, y}, e_xy);
        end
        chk("pix_mode", mode, exp_mode);
      end
    end
  end

  // One raster of VTOT lines; vsync rises at the start of line VACT+1.
  task automatic run_frame(input bit exp_tick, input bit exp_ack, input logic [2:0] mode_after,
                           input int req_line, input bit req_at_fs);
    pix_cnt = 0;
    for (int line = 0; line < VTOT; line++) begin
      for (int col = 0; col < HTOT; col++) begin
        vvalid = (line < VACT);
        hvalid = vvalid && (col < HACT);
        vsync  = (line >= VACT + 1) && (line <= VACT + 2);
        if (hvalid) xy_q.push_back({10'd0, 11'(col), 11'(line)});
        if (line == req_line && col == 0) cfg_req = 1'b1;
        if (line == VACT + 1 && col == 0) begin
          if (req_at_fs) cfg_req = 1'b1;
          chk("fc_before_fs", frame_cnt, exp_fc);
          step();
          exp_fc = exp_fc + 8'd1;
          chk("fc_after_fs", frame_cnt, exp_fc);
          chk("ack_at_fs", cfg_ack, exp_ack);
          chk("tick_at_fs", anim_tick, exp_tick);
          chk("mode_at_fs", mode, mode_after);
          exp_mode = mode_after;
          exp_ticks += int'(exp_tick);
        end else begin
          step();
        end
      end
    end
    chk("pix_count", pix_cnt, HACT * VACT);
    chk("sync_err_frame", sync_err, 0);
  endtask

  initial begin
    #2 RSTn = 1'b0;
    #1 chk_reset();
    step();
    step();
    RSTn = 1'b1;

    // speed 0: a tick and a frame count on every frame
    for (int f = 0; f < 3; f++) run_frame(1'b1, 1'b0, 3'd0, -1, 1'b0);
    chk("anim_3frames", tick_cnt, 3);

    // mid-frame request: mode held until fs, old speed still ticks at commit
    cfg_mode = 3'd5;
    cfg_speed = 4'd2;
    run_frame(1'b1, 1'b1, 3'd5, 2, 1'b0);
    run_frame(1'b0, 1'b0, 3'd5, -1, 1'b0);
    cfg_req = 1'b0;
    run_frame(1'b0, 1'b0, 3'd5, -1, 1'b0);
    run_frame(1'b1, 1'b0, 3'd5, -1, 1'b0);
    run_frame(1'b0, 1'b0, 3'd5, -1, 1'b0);

    // request coincident with fs: latched only, committed one frame later
    cfg_mode = 3'd3;
    cfg_speed = 4'd0;
    run_frame(1'b0, 1'b0, 3'd5, -1, 1'b1);
    run_frame(1'b1, 1'b1, 3'd3, -1, 1'b0);
    cfg_req = 1'b0;
    run_frame(1'b1, 1'b0, 3'd3, -1, 1'b0);

    // line overrun: x saturates, sync_err sticks until reset
    vvalid = 1'b1;
    for (int col = 0; col <= HACT; col++) begin
      hvalid = 1'b1;
      xy_q.push_back({10'd0, 11'((col < HACT) ? col : HACT - 1), 11'd0});
      step();
    end
    chk("ovf_x_sat", x, HACT - 1);
    chk("ovf_sync_err", sync_err, 1);
    hvalid = 1'b0;
    step();
    vvalid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("ovf_sticky", sync_err, 1);
    RSTn = 1'b0;
    #1 chk("ovf_cleared", sync_err, 0);
    exp_fc = 8'd0;
    exp_mode = 3'd0;
    step();
    RSTn = 1'b1;
    step();

    // reset while PEND: request discarded, no later ack
    cfg_mode = 3'd6;
    cfg_speed = 4'd1;
    cfg_req = 1'b1;
    step();
    step();
    @(posedge clk);
    #3 RSTn = 1'b0;
    #1 chk_reset();
    cfg_req = 1'b0;
    xy_q.delete();
    step();
    RSTn = 1'b1;
    step();
    run_frame(1'b1, 1'b0, 3'd0, -1, 1'b0);

    chk("ack_total", ack_cnt, 2);
    chk("tick_total", tick_cnt, exp_ticks);
    chk("queue_drained", xy_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
